// File: rtl/ltc2333_pkg.sv
// rtl/ltc2333_pkg.sv - shared types, constants and control-word helpers for the LTC2333 sequencer
package ltc2333_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNV,
        CONVERT,
        SHIFT,
        GAP
    } state_t;

    localparam int LTC2333_NCH        = 8;
    localparam int LTC2333_FRAME_BITS = 24;
    localparam int LTC2333_CW_BITS    = 8;

    // SoftSpan control word: valid bit, channel id, reserved zero, span code
    function automatic logic [LTC2333_CW_BITS-1:0] ltc2333_cw(input logic [2:0] ch,
                                                              input logic [2:0] sp);
        return {1'b1, ch, 1'b0, sp};
    endfunction

    // Pick the 3-bit span code of one channel out of the packed span vector
    function automatic logic [2:0] ltc2333_span_of(input logic [3*LTC2333_NCH-1:0] spans,
                                                   input logic [2:0] ch);
        return spans[3*ch +: 3];
    endfunction

endpackage

// File: rtl/ltc2333_chan_sel.sv
// rtl/ltc2333_chan_sel.sv - lowest set bit of an 8-bit channel mask at or above a start index
module ltc2333_chan_sel
    import ltc2333_pkg::*;
(
    input  logic [LTC2333_NCH-1:0] mask,
    input  logic [3:0]             start,
    output logic                   found,
    output logic [2:0]             idx
);

    // Scan from the top down so the lowest qualifying channel is the one left standing
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = LTC2333_NCH - 1; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= start)) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/ltc2333_ctrl.sv
// rtl/ltc2333_ctrl.sv - LTC2333 conversion trigger, CNV/SCKI timing and SoftSpan SDI sequencer
module ltc2333_ctrl
    import ltc2333_pkg::*;
#(
    parameter int CLK_DIV         = 2,
    parameter int CNV_HIGH_CYCLES = 8,
    parameter int CONV_CYCLES     = 100,
    parameter int GAP_CYCLES      = 4,
    parameter int PERIOD_W        = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         ext_trig,
    input  logic [PERIOD_W-1:0]          period,
    input  logic [LTC2333_NCH-1:0]       chan_mask,
    input  logic [3*LTC2333_NCH-1:0]     span,
    output logic                         cnv,
    output logic                         scki,
    output logic                         sdi,
    output logic                         busy,
    output logic                         frame_done,
    output logic [15:0]                  overrun_cnt
);

    localparam int TMR_W = 16;
    localparam int PAD_W = LTC2333_FRAME_BITS - LTC2333_CW_BITS;

    state_t                        state;
    logic [PERIOD_W-1:0]           per_cnt;
    logic                          per_match;
    logic                          trig;
    logic [TMR_W-1:0]              tmr;
    logic [LTC2333_NCH-1:0]        mask_l;
    logic [3*LTC2333_NCH-1:0]      span_l;
    logic [3:0]                    n_act;
    logic [3:0]                    pop;
    logic [2:0]                    cur_ch;
    logic [2:0]                    frame_cnt;
    logic [4:0]                    bit_cnt;
    logic [LTC2333_FRAME_BITS-1:0] sr;
    logic [LTC2333_NCH-1:0]        sel_mask;
    logic [3:0]                    sel_start;
    logic                          sel_found;
    logic [2:0]                    sel_idx;
    logic [LTC2333_FRAME_BITS-1:0] first_word;
    logic [LTC2333_FRAME_BITS-1:0] next_word;

    assign per_match = (period != '0) && (per_cnt == period - PERIOD_W'(1));
    assign trig      = enable && (ext_trig || per_match);

    // Outside IDLE the selector walks the latched mask from the channel after the current one
    assign sel_mask  = (state == IDLE) ? chan_mask : mask_l;
    assign sel_start = (state == IDLE) ? 4'd0 : ({1'b0, cur_ch} + 4'd1);

    ltc2333_chan_sel u_chan_sel (
        .mask  (sel_mask),
        .start (sel_start),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign first_word = {ltc2333_cw(cur_ch, ltc2333_span_of(span_l, cur_ch)), {PAD_W{1'b0}}};
    assign next_word  = {ltc2333_cw(sel_idx, ltc2333_span_of(span_l, sel_idx)), {PAD_W{1'b0}}};

    // SDI is always the MSB of the frame shift register, so it stays a registered output
    assign sdi = sr[LTC2333_FRAME_BITS-1];

    // Number of enabled channels in the live mask, latched at trigger time
    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < LTC2333_NCH; i++) begin
            pop = pop + 4'(chan_mask[i]);
        end
    end

    // Free-running period counter, parked at zero while periodic triggering is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (!enable || (period == '0) || per_match) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PERIOD_W'(1);
        end
    end

    // Sequencer: trigger, CNV pulse, conversion wait, per-channel SCKI frames, guard gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnv         <= 1'b0;
            scki        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun_cnt <= 16'd0;
            tmr         <= '0;
            mask_l      <= '0;
            span_l      <= '0;
            n_act       <= 4'd0;
            cur_ch      <= 3'd0;
            frame_cnt   <= 3'd0;
            bit_cnt     <= 5'd0;
            sr          <= '0;
        end else begin
            frame_done <= 1'b0;
            if (trig && (state != IDLE) && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (trig && sel_found) begin
                        mask_l <= chan_mask;
                        span_l <= span;
                        n_act  <= pop;
                        cur_ch <= sel_idx;
                        cnv    <= 1'b1;
                        busy   <= 1'b1;
                        tmr    <= '0;
                        state  <= CNV;
                    end
                end
                CNV: begin
                    if (tmr == TMR_W'(CNV_HIGH_CYCLES - 1)) begin
                        cnv   <= 1'b0;
                        tmr   <= '0;
                        state <= CONVERT;
                        if (CONV_CYCLES == 1) begin
                            sr <= first_word;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                CONVERT: begin
                    if ((CONV_CYCLES >= 2) && (tmr == TMR_W'(CONV_CYCLES - 2))) begin
                        sr <= first_word;
                    end
                    if (tmr == TMR_W'(CONV_CYCLES - 1)) begin
                        tmr       <= '0;
                        bit_cnt   <= 5'd0;
                        frame_cnt <= 3'd0;
                        state     <= SHIFT;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                SHIFT: begin
                    if (tmr == TMR_W'(CLK_DIV - 1)) begin
                        tmr <= '0;
                        if (!scki) begin
                            scki <= 1'b1;
                        end else begin
                            scki <= 1'b0;
                            if (bit_cnt == 5'(LTC2333_FRAME_BITS - 1)) begin
                                bit_cnt <= 5'd0;
                                if ({1'b0, frame_cnt} == n_act - 4'd1) begin
                                    sr         <= '0;
                                    frame_done <= 1'b1;
                                    state      <= GAP;
                                end else begin
                                    frame_cnt <= frame_cnt + 3'd1;
                                    cur_ch    <= sel_idx;
                                    sr        <= next_word;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                sr      <= {sr[LTC2333_FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (tmr == TMR_W'(GAP_CYCLES - 1)) begin
                        tmr   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ltc2333_ctrl.md
Name: ltc2333_ctrl

Overview:
Master-side sequencer for the LTC2333 8-channel SAR ADC. Issues CNV, waits out the conversion, then drives SCKI for one 24-bit frame per enabled channel. During readout it shifts SoftSpan control words onto SDI. The ADC's echoed SCKO/SDO return path is captured by the existing LTC2333 reader block, which resets its deserializer on CNV and counts 12 SCKO rising edges per 24-bit DDR word.

Parameters:
CLK_DIV, 2, clk cycles per SCKI half-period (>=1)
CNV_HIGH_CYCLES, 8, clk cycles CNV held high (>=1)
CONV_CYCLES, 100, clk cycles from CNV falling to first SCKI edge (covers tCONV)
GAP_CYCLES, 4, idle clk cycles after last SCKI falling edge before next trigger accepted
PERIOD_W, 32, width of free-running trigger period register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
enable  in  1  1 = accept triggers (periodic and external)
ext_trig  in  1  single-cycle external trigger, sync to clk
period  in  PERIOD_W  periodic trigger interval in clk cycles; 0 = periodic off
chan_mask  in  8  channel enable bit per channel, sampled at trigger
span  in  24  3-bit SoftSpan code per channel, ch n at [3n+2:3n], sampled at trigger
cnv  out  1  ADC convert start
scki  out  1  ADC serial clock
sdi  out  1  ADC serial config data
busy  out  1  high from accepted trigger until return to IDLE
frame_done  out  1  one-cycle pulse when last SCKI falling edge is issued
overrun_cnt  out  16  count of triggers dropped while busy; saturates at 0xFFFF

Behaviour:
- Reset (async): state=IDLE; cnv=0, scki=0, sdi=0, busy=0, frame_done=0, overrun_cnt=0; period counter=0.
- Trigger = ext_trig OR (period!=0 AND period counter reached period-1). Period counter increments every clk and wraps to 0 on the match, regardless of state. Counter is held at 0 while enable=0 or period=0.
- In IDLE with enable=1 and chan_mask!=0: a trigger latches chan_mask/span, computes n_act = popcount(mask) (4-bit, 1..8), and enters CNV. busy rises the next cycle.
- In IDLE with chan_mask==0: triggers are ignored and not counted.
- Trigger while busy (any state other than IDLE): dropped; overrun_cnt += 1 (saturating).
- ext_trig and periodic match in the same cycle count as one trigger.
- CNV: cnv=1 for CNV_HIGH_CYCLES, then CONVERT.
- CONVERT: cnv=0 and scki=0 for CONV_CYCLES. sdi presents bit 23 of frame 0 one cycle before leaving.
- SHIFT: n_act*24 SCKI periods, each CLK_DIV cycles low then CLK_DIV cycles high. The phase starts low, so the first rising edge comes CLK_DIV cycles after entry.
  - sdi updates only on SCKI falling edges, or at SHIFT entry for the first bit. The ADC samples on the rising edge.
  - Frame k (k=0..n_act-1) carries the k-th set bit of the latched mask, in ascending order, as channel c.
  - Frame bits 23..16 = {1'b1, c[2:0], 1'b0, span_c[2:0]}, MSB first; bits 15..0 = 0.
  - Bit counter 0..23 wraps per frame; frame counter 0..n_act-1.
- After the final falling edge: scki=0, sdi=0, frame_done pulses 1 cycle, then GAP for GAP_CYCLES, then IDLE with busy=0.
- enable deasserted mid-sequence: the current sequence completes; only new triggers are blocked.
- Async reset mid-sequence: all outputs go to reset values immediately. A partially clocked frame is discarded; the reader clears on the next CNV.
- All outputs are registered, with no combinational path from inputs to cnv/scki/sdi.

Decomposition:
- Package ltc2333_pkg:
  - state enum {IDLE, CNV, CONVERT, SHIFT, GAP}
  - LTC2333_NCH=8, LTC2333_FRAME_BITS=24, LTC2333_CW_BITS=8
  - function making the control word from (ch, span)
- One sub-module, ltc2333_chan_sel: combinational "next set bit at or above index" over the 8-bit latched mask. Used to pick c for each frame.

Test Plan:
- mask=0x01, span0=3'b111, CLK_DIV=2, ext_trig pulse -> cnv high 8 cycles; 24 SCKI periods of 4 clk each; sdi bits 23..16 = 1000_0111, then 16 zeros; frame_done once; busy falls after GAP.
- mask=0xA5, spans=ch n->n -> 4 frames in channel order 0,2,5,7; control words 0x80,0xA2,0xD5,0xF7; 96 SCKI rising edges total.
- period=1000, ext_trig unused, enable=1 for 5000 cycles -> cnv rising edges exactly 1000 cycles apart; overrun_cnt=0.
- period=50 with mask=0xFF (sequence > 50 cycles) -> triggers during busy increment overrun_cnt; it saturates at 0xFFFF when forced long.
- Assert reset during SHIFT, mid-frame 3 -> cnv/scki/sdi/busy=0 same cycle; next trigger restarts at frame 0 with correct control word.
- Protocol loopback: model the ADC echoing SCKI as SCKO and returning a known 24-bit pattern on SDO into the reader block -> reader FIFO receives n_act words, each matching the pattern.
